// File: rtl/hwag_spi_pkg.sv
// Shared constants and FSM state type for the HWAG SPI frame format (both directions).
// Frame: cmd, addr, data[7:0..31:24], crc -- seven bytes, CRC-8 poly 0x07 over bytes 0..5.
// No logic here; imported by the framers and the CRC step.
package hwag_spi_pkg;

  localparam int         FRAME_LEN = 7;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  // Byte positions within a frame
  localparam logic [2:0] IDX_CMD   = 3'd0;
  localparam logic [2:0] IDX_ADDR  = 3'd1;
  localparam logic [2:0] IDX_DATA0 = 3'd2;
  localparam logic [2:0] IDX_DATA3 = 3'd5;
  localparam logic [2:0] IDX_CRC   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_READY,
    ST_SEND,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/hwag_spi_tx_data_frame_if.sv
// Signal bundle between the transmit framer, the response source and the SPI core.
// master = source/SPI-core side, slave = framer side.
// Pure wiring, no timing of its own.
interface hwag_spi_tx_data_frame_if;

  logic        spi_ss;
  logic        spi_tx;
  logic        tx_load;
  logic [7:0]  tx_cmd;
  logic [7:0]  tx_addr;
  logic [31:0] tx_data;
  logic [7:0]  spi_bus_in;
  logic [7:0]  tx_crc;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_abort;
  logic        tx_underrun;

  modport master (
    output spi_ss, spi_tx, tx_load, tx_cmd, tx_addr, tx_data,
    input  spi_bus_in, tx_crc, tx_ready, tx_busy, tx_done, tx_abort, tx_underrun
  );

  modport slave (
    input  spi_ss, spi_tx, tx_load, tx_cmd, tx_addr, tx_data,
    output spi_bus_in, tx_crc, tx_ready, tx_busy, tx_done, tx_abort, tx_underrun
  );

endinterface

// File: rtl/hwag_crc8_byte.sv
// One-byte CRC-8 step (poly 0x07, MSB-first, no reflection), shared with the receive side.
// Latency: purely combinational.
// Backpressure: none.
module hwag_crc8_byte
  import hwag_spi_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // Fold the byte into the remainder, then shift out eight bits
  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/hwag_spi_tx_data_frame.sv
// Transmit framer: latches cmd/addr/data, CRCs them in 6 cycles, then feeds bytes to the SPI shifter.
// Latency: tx_load -> tx_ready/byte 0 in 7 cycles; spi_tx -> next byte on spi_bus_in 1 cycle later.
// Backpressure: tx_load ignored while busy; spi_ss rise mid-frame aborts back to READY keeping the frame.
module hwag_spi_tx_data_frame
  import hwag_spi_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter logic [7:0] CRC_INIT = 8'h00
)(
  input  logic                      clk,
  input  logic                      rst,
  hwag_spi_tx_data_frame_if.slave   bus
);

  tx_state_e  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] crc_q, crc_d, crc_step;
  logic [7:0] frame_q [0:FRAME_LEN-2];
  logic [7:0] byte_mux [0:7];
  logic [7:0] bus_q, bus_d;
  logic       load_en;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       underrun_q, underrun_d;
  logic       strobe;

  // A byte-complete strobe only counts while the slave is selected
  assign strobe = bus.spi_tx & ~bus.spi_ss;

  // Full 8-entry view of the frame so any 3-bit index is in range; slot 7 is never sent
  always_comb begin
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      byte_mux[i] = frame_q[i];
    end
    byte_mux[IDX_CRC] = crc_q;
    byte_mux[7]       = PAD_BYTE;
  end

  // During CALC the index walks bytes 0..5 through the CRC step
  hwag_crc8_byte u_crc (
    .crc_in  (crc_q),
    .byte_in (byte_mux[idx_q]),
    .crc_out (crc_step)
  );

  // Next-state, index, CRC and pulse decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    load_en    = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    underrun_d = 1'b0;
    bus_d      = PAD_BYTE;

    case (state_q)
      ST_IDLE: begin
        underrun_d = strobe;
        if (bus.tx_load) begin
          load_en = 1'b1;
          crc_d   = CRC_INIT;
          idx_d   = IDX_CMD;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        underrun_d = strobe;
        crc_d      = crc_step;
        if (idx_q == IDX_DATA3) begin
          idx_d   = IDX_CMD;
          state_d = ST_READY;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_READY: begin
        // Reload only while deselected so a transfer never sees a half-swapped frame
        if (bus.tx_load && bus.spi_ss) begin
          load_en = 1'b1;
          crc_d   = CRC_INIT;
          idx_d   = IDX_CMD;
          state_d = ST_CALC;
        end else if (strobe) begin
          idx_d   = IDX_ADDR;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Deselect beats a coincident strobe: the index rewinds instead of advancing
        if (bus.spi_ss) begin
          abort_d = 1'b1;
          idx_d   = IDX_CMD;
          state_d = ST_READY;
        end else if (bus.spi_tx) begin
          if (idx_q == IDX_CRC) begin
            done_d  = 1'b1;
            idx_d   = IDX_CMD;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (bus.spi_ss) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_CMD;
      end
    endcase

    // Registered byte tracks the state being entered
    case (state_d)
      ST_READY: bus_d = byte_mux[IDX_CMD];
      ST_SEND:  bus_d = byte_mux[idx_d];
      default:  bus_d = PAD_BYTE;
    endcase
  end

  // State, index, CRC and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= IDX_CMD;
      crc_q      <= CRC_INIT;
      bus_q      <= PAD_BYTE;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      bus_q      <= bus_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  // Frame payload capture on an accepted load
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        frame_q[i] <= 8'h00;
      end
    end else if (load_en) begin
      frame_q[IDX_CMD]        <= bus.tx_cmd;
      frame_q[IDX_ADDR]       <= bus.tx_addr;
      frame_q[IDX_DATA0]      <= bus.tx_data[7:0];
      frame_q[IDX_DATA0 + 1]  <= bus.tx_data[15:8];
      frame_q[IDX_DATA0 + 2]  <= bus.tx_data[23:16];
      frame_q[IDX_DATA3]      <= bus.tx_data[31:24];
    end
  end

  assign bus.spi_bus_in  = bus_q;
  assign bus.tx_crc      = crc_q;
  assign bus.tx_ready    = (state_q == ST_READY);
  assign bus.tx_busy     = (state_q == ST_CALC) || (state_q == ST_SEND) || (state_q == ST_DONE);
  assign bus.tx_done     = done_q;
  assign bus.tx_abort    = abort_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
// Directed bench for the transmit framer: a table of frames with hand-computed bytes/CRC,
// plus hand-written sequences for underrun, overrun, abort/retry, reset and reload.
module tb_hwag_spi_tx_data_frame;

  typedef struct packed {
    logic [7:0]        cmd;
    logic [7:0]        addr;
    logic [31:0]       data;
    logic [7:0]        crc;
    logic [0:6][7:0]   exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [3];

  hwag_spi_tx_data_frame_if bus_if ();

  hwag_spi_tx_data_frame #(
    .PAD_BYTE (8'h00),
    .CRC_INIT (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe();
    bus_if.spi_tx = 1'b1;
    step();
    bus_if.spi_tx = 1'b0;
  endtask

  // Load a frame with ss high and check the 7-cycle path to READY
  task automatic load_and_wait(input vec_t v);
    bus_if.spi_ss  = 1'b1;
    bus_if.tx_cmd  = v.cmd;
    bus_if.tx_addr = v.addr;
    bus_if.tx_data = v.data;
    bus_if.tx_load = 1'b1;
    step();
    bus_if.tx_load = 1'b0;
    chk("busy_in_calc", 32'(bus_if.tx_busy), 32'd1);
    repeat (5) step();
    chk("ready_not_early", 32'(bus_if.tx_ready), 32'd0);
    step();
    chk("ready_at_t7", 32'(bus_if.tx_ready), 32'd1);
    chk("crc_at_t7", 32'(bus_if.tx_crc), 32'(v.crc));
    chk("byte0_at_t7", 32'(bus_if.spi_bus_in), 32'(v.exp[0]));
    chk("busy_in_ready", 32'(bus_if.tx_busy), 32'd0);
  endtask

  // Shift out a whole frame, then an extra strobe in DONE, then deselect
  task automatic send_full(input vec_t v);
    bus_if.spi_ss = 1'b0;
    for (int k = 1; k < 7; k++) begin
      strobe();
      chk($sformatf("byte%0d", k), 32'(bus_if.spi_bus_in), 32'(v.exp[k]));
    end
    strobe();
    chk("done_pulse", 32'(bus_if.tx_done), 32'd1);
    chk("pad_in_done", 32'(bus_if.spi_bus_in), 32'h00);
    step();
    chk("done_one_cycle", 32'(bus_if.tx_done), 32'd0);
    strobe();
    chk("overrun_no_done", 32'(bus_if.tx_done), 32'd0);
    chk("overrun_no_underrun", 32'(bus_if.tx_underrun), 32'd0);
    chk("overrun_pad", 32'(bus_if.spi_bus_in), 32'h00);
    chk("busy_in_done", 32'(bus_if.tx_busy), 32'd1);
    bus_if.spi_ss = 1'b1;
    step();
    chk("idle_after_ss", 32'(bus_if.tx_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0].cmd = 8'h00; vecs[0].addr = 8'h00; vecs[0].data = 32'h0000_0000; vecs[0].crc = 8'h00;
    vecs[0].exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].cmd = 8'h00; vecs[1].addr = 8'h00; vecs[1].data = 32'h0100_0000; vecs[1].crc = 8'h07;
    vecs[1].exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
    vecs[2].cmd = 8'hA5; vecs[2].addr = 8'h3C; vecs[2].data = 32'h1122_3344; vecs[2].crc = 8'hF6;
    vecs[2].exp = {8'hA5, 8'h3C, 8'h44, 8'h33, 8'h22, 8'h11, 8'hF6};

    rst            = 1'b1;
    bus_if.spi_ss  = 1'b1;
    bus_if.spi_tx  = 1'b0;
    bus_if.tx_load = 1'b0;
    bus_if.tx_cmd  = 8'h00;
    bus_if.tx_addr = 8'h00;
    bus_if.tx_data = 32'h0;
    repeat (3) step();

    chk("rst_bus", 32'(bus_if.spi_bus_in), 32'h00);
    chk("rst_crc", 32'(bus_if.tx_crc), 32'h00);
    chk("rst_ready", 32'(bus_if.tx_ready), 32'd0);
    chk("rst_busy", 32'(bus_if.tx_busy), 32'd0);
    chk("rst_flags", 32'({bus_if.tx_done, bus_if.tx_abort, bus_if.tx_underrun}), 32'd0);
    rst = 1'b0;
    step();

    // Underrun: strobe while selected in IDLE
    bus_if.spi_ss = 1'b0;
    strobe();
    chk("underrun_pulse", 32'(bus_if.tx_underrun), 32'd1);
    chk("underrun_pad", 32'(bus_if.spi_bus_in), 32'h00);
    chk("underrun_stays_idle", 32'(bus_if.tx_busy), 32'd0);
    step();
    chk("underrun_one_cycle", 32'(bus_if.tx_underrun), 32'd0);
    bus_if.spi_ss = 1'b1;
    step();

    // Table-driven frames
    for (int i = 0; i < 3; i++) begin
      load_and_wait(vecs[i]);
      send_full(vecs[i]);
    end

    // Abort after three strobes, then an identical retry
    load_and_wait(vecs[2]);
    bus_if.spi_ss = 1'b0;
    repeat (3) strobe();
    chk("pre_abort_byte3", 32'(bus_if.spi_bus_in), 32'h33);
    bus_if.spi_ss = 1'b1;
    step();
    chk("abort_pulse", 32'(bus_if.tx_abort), 32'd1);
    chk("abort_byte0", 32'(bus_if.spi_bus_in), 32'hA5);
    chk("abort_ready", 32'(bus_if.tx_ready), 32'd1);
    chk("abort_crc_kept", 32'(bus_if.tx_crc), 32'hF6);
    step();
    chk("abort_one_cycle", 32'(bus_if.tx_abort), 32'd0);
    send_full(vecs[2]);

    // Strobe and deselect together: abort wins, index rewinds
    load_and_wait(vecs[2]);
    bus_if.spi_ss = 1'b0;
    repeat (2) strobe();
    bus_if.spi_ss = 1'b1;
    strobe();
    chk("sim_abort_pulse", 32'(bus_if.tx_abort), 32'd1);
    chk("sim_abort_byte0", 32'(bus_if.spi_bus_in), 32'hA5);
    bus_if.spi_ss = 1'b0;
    strobe();
    chk("sim_retry_byte1", 32'(bus_if.spi_bus_in), 32'h3C);
    strobe();
    chk("sim_retry_byte2", 32'(bus_if.spi_bus_in), 32'h44);

    // Reset in SEND with ss still low: back to IDLE, no abort
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bus", 32'(bus_if.spi_bus_in), 32'h00);
    chk("midrst_crc", 32'(bus_if.tx_crc), 32'h00);
    chk("midrst_ready", 32'(bus_if.tx_ready), 32'd0);
    chk("midrst_busy", 32'(bus_if.tx_busy), 32'd0);
    chk("midrst_flags", 32'({bus_if.tx_done, bus_if.tx_abort, bus_if.tx_underrun}), 32'd0);
    step();
    chk("midrst_no_abort", 32'(bus_if.tx_abort), 32'd0);
    bus_if.spi_ss = 1'b1;
    step();

    // Reload from READY while deselected replaces frame and CRC
    load_and_wait(vecs[1]);
    load_and_wait(vecs[2]);
    send_full(vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hwag_spi_tx_data_frame.md
# hwag_spi_tx_data_frame

Transmit-side framer for the HWAG SPI slave link. Latches a response (command, address, 32-bit data), computes its CRC-8, and presents the 7-byte frame one byte at a time to the SPI shift register, advancing on each byte-complete strobe while chip select is low. The frame layout matches the receive framer, so both directions share one frame format and one CRC.

## Interface
Parameters:
- PAD_BYTE, 8'h00: byte presented in every state other than READY and SEND.
- CRC_INIT, 8'h00: CRC seed value.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- spi_ss  in  1  chip select, active low (1 = deselected).
- spi_tx  in  1  one-cycle strobe from the SPI core: current byte fully shifted.
- tx_load  in  1  one-cycle strobe: latch tx_cmd/tx_addr/tx_data.
- tx_cmd  in  8  response command byte.
- tx_addr  in  8  response address byte.
- tx_data  in  32  response data word.
- spi_bus_in  out  8  registered byte for the SPI shift register.
- tx_crc  out  8  CRC of the latched frame, valid while tx_ready=1 or in SEND.
- tx_ready  out  1  frame latched, CRC complete, transfer not yet started.
- tx_busy  out  1  high in CALC, SEND and DONE.
- tx_done  out  1  one-cycle pulse when byte 6 completes.
- tx_abort  out  1  one-cycle pulse when spi_ss rises mid-frame.
- tx_underrun  out  1  one-cycle pulse on spi_tx with spi_ss=0 in IDLE or CALC.

## Operation
- Frame byte order: 0 cmd, 1 addr, 2 data[7:0], 3 data[15:8], 4 data[23:16], 5 data[31:24], 6 crc.
- CRC-8 settings: polynomial 0x07, seed CRC_INIT, MSB-first, no reflection, no final XOR. The CRC covers bytes 0..5.
- FSM states: IDLE, CALC, READY, SEND, DONE.
- IDLE:
  - tx_load latches the frame, clears the CRC to CRC_INIT and moves to CALC.
  - spi_bus_in = PAD_BYTE.
- CALC:
  - Absorbs bytes 0..5, one per cycle (6 cycles), then moves to READY.
  - tx_load is ignored.
- READY:
  - spi_bus_in = byte 0 and byte index = 0.
  - tx_load with spi_ss=1 replaces the frame and re-enters CALC.
  - The first spi_tx with spi_ss=0 moves to SEND with index 1.
- SEND:
  - spi_bus_in = byte[index].
  - Each spi_tx increments the index.
  - spi_tx at index 6 pulses tx_done and moves to DONE.
- DONE:
  - spi_bus_in = PAD_BYTE.
  - Further spi_tx strobes are ignored with no flag.
  - spi_ss=1 moves to IDLE.
- Abort: spi_ss=1 while in SEND pulses tx_abort and returns to READY with index 0. The frame and CRC are kept, so a retry resends the identical frame.
- Underrun: spi_tx with spi_ss=0 in IDLE or CALC pulses tx_underrun; the state is unchanged.
- Simultaneous events:
  - tx_load and spi_tx in IDLE: the load is taken and tx_underrun still pulses.
  - spi_tx and an spi_ss rise in the same cycle in SEND: the abort wins and the index is not advanced.
- tx_load in SEND or DONE is ignored; the source must wait for tx_busy=0.

## Timing
- Reset values: state IDLE, spi_bus_in=PAD_BYTE, tx_crc=CRC_INIT, and tx_ready, tx_busy, tx_done, tx_abort, tx_underrun all 0.
- Reset mid-frame: the next cycle is IDLE with the outputs above, and no tx_abort pulse.
- Load-to-ready latency: tx_load at cycle T gives tx_ready=1 and spi_bus_in=cmd at T+7.
- Byte advance: spi_tx at cycle T updates spi_bus_in at T+1. The SPI core must sample spi_bus_in no earlier than one cycle after its spi_tx strobe.
- Pulse timing: tx_done, tx_abort and tx_underrun are registered and asserted in the cycle after the causing event.
- spi_ss is sampled as-is; it must already be synchronous to clk.

## Structure
- Shared package hwag_spi_pkg holds:
  - FRAME_LEN=7 and CRC_POLY=8'h07;
  - byte index constants IDX_CMD=0, IDX_ADDR=1, IDX_DATA0=2, IDX_CRC=6;
  - the typedef enum for the FSM states.
- Sub-module hwag_crc8_byte: a combinational one-byte CRC-8 step (crc_in, byte_in -> crc_out). The receive-side CRC unit is permitted to reuse it.
- The frame is stored as seven 8-bit registers selected by a 3-bit index.

## Test plan
- Zero frame: load cmd=0x00, addr=0x00, data=0 -> tx_crc=0x00 at T+7; seven strobes with ss=0 give bytes 00 00 00 00 00 00 00, then a tx_done pulse.
- CRC check: load cmd=0x00, addr=0x00, data=0x01000000 -> bytes 00 00 00 00 00 01 07, tx_crc=0x07.
- Ordering: load cmd=0xA5, addr=0x3C, data=0x11223344 -> bytes A5 3C 44 33 22 11 then crc, and the same frame loopbacks through the receive framer with spi_crc_rx_equal=1.
- Abort/retry: raise ss after 3 strobes -> tx_abort pulse, spi_bus_in=0xA5; a full retry resends the identical 7 bytes.
- Underrun/overrun: spi_tx with ss=0 in IDLE -> tx_underrun pulse and spi_bus_in=0x00; an 8th strobe in DONE -> no flag and spi_bus_in=0x00.
- Reset and reload: rst asserted in SEND -> IDLE, all outputs at reset values; tx_load in READY with ss=1 -> the new frame and its CRC appear 7 cycles later.
